// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port RAM with 1-cycle registered reads.
// Define ARB_LOCK_EN to let a requester hold the grant across a multi-word burst via reqN_lock.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_lock,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_lock,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic                  last_grant;
    logic                  rsp_pending;
    logic                  rsp_tag;
    logic [ADDR_WIDTH-1:0] ram_a_q;

    logic                  grant_valid;
    logic                  grant_id;
    logic                  accept;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {LOCK_NONE, LOCK_OWN0, LOCK_OWN1} lock_state_t;

    lock_state_t lock_owner;
    lock_state_t lock_next;
    logic        win_lock;

    always_ff @(posedge clk) begin
        if (!reset_n) lock_owner <= LOCK_NONE;
        else          lock_owner <= lock_next;
    end

    // An owner keeps the port even while idle; dropping valid releases it.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        lock_next   = lock_owner;
        win_lock    = 1'b0;
        case (lock_owner)
            LOCK_OWN0: begin
                grant_valid = req0_valid;
                grant_id    = 1'b0;
                if (!req0_valid || (reset_n && !req0_lock)) lock_next = LOCK_NONE;
            end
            LOCK_OWN1: begin
                grant_valid = req1_valid;
                grant_id    = 1'b1;
                if (!req1_valid || (reset_n && !req1_lock)) lock_next = LOCK_NONE;
            end
            LOCK_NONE: begin
                grant_valid = req0_valid | req1_valid;
                grant_id    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
                win_lock    = grant_id ? req1_lock : req0_lock;
                if (grant_valid && reset_n && win_lock)
                    lock_next = grant_id ? LOCK_OWN1 : LOCK_OWN0;
            end
            default: lock_next = LOCK_NONE;
        endcase
    end
`else
    logic unused_lock;
    assign unused_lock = req0_lock ^ req1_lock;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    end
`endif

    assign accept     = grant_valid & reset_n;
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;

    assign win_we    = grant_id ? req1_we    : req0_we;
    assign win_addr  = grant_id ? req1_addr  : req0_addr;
    assign win_wdata = grant_id ? req1_wdata : req0_wdata;

    // With no winner the address stays parked on the last access.
    assign ram_a  = grant_valid ? win_addr : ram_a_q;
    assign ram_d  = grant_valid ? win_wdata : '0;
    assign ram_we = accept & win_we;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant  <= 1'b1;
            rsp_pending <= 1'b0;
            rsp_tag     <= 1'b0;
            ram_a_q     <= '0;
        end else begin
            rsp_pending <= accept & ~win_we;
            if (accept) begin
                last_grant <= grant_id;
                rsp_tag    <= grant_id;
                ram_a_q    <= win_addr;
            end
        end
    end

    assign rsp0_valid = rsp_pending & ~rsp_tag;
    assign rsp1_valid = rsp_pending & rsp_tag;
    assign rsp0_rdata = rsp0_valid ? ram_q : '0;
    assign rsp1_rdata = rsp1_valid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with a behavioural single-port RAM (registered read, read-old-data).
// Lock-burst expectations follow the ARB_LOCK_EN build option.
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_we, req0_lock, rsp0_valid;
    logic [9:0]  req0_addr;
    logic [15:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_lock, rsp1_valid;
    logic [9:0]  req1_addr;
    logic [15:0] req1_wdata, rsp1_rdata;
    logic [9:0]  ram_a;
    logic [15:0] ram_d, ram_q;
    logic        ram_we;

    logic [15:0] mem [0:1023];

    int vectors    = 0;
    int miscompares = 0;

    ram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stub: reloads data=addr while in reset so reads have known contents.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'(i);
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
        ram_q <= mem[ram_a];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic we0, input logic [9:0] a0,
                                 input logic [15:0] d0, input logic l0,
                                 input logic v1, input logic we1, input logic [9:0] a1,
                                 input logic [15:0] d1, input logic l1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0; req0_lock = l0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1; req1_lock = l1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int  n0, n1, g, c, exp_g, prev_g;
    logic lock_build;

    initial begin
`ifdef ARB_LOCK_EN
        lock_build = 1'b1;
`else
        lock_build = 1'b0;
`endif
        reset_n = 1'b0;
        applyStimulus(1, 0, 10'h000, 16'h0, 0, 1, 0, 10'h100, 16'h0, 0);

        // Reset held with both requesters valid.
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("rst_ready0", req0_ready, 0);
            checkOutput("rst_ready1", req1_ready, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_rsp0_valid", rsp0_valid, 0);
            checkOutput("rst_rsp1_valid", rsp1_valid, 0);
        end

        // Full read contention straight out of reset: grants 0,1,0,1,...
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            n0 = (cyc + 1) / 2;
            n1 = cyc / 2;
            applyStimulus(n0 < 4, 0, 10'(n0), 16'h0, 0, n1 < 4, 0, 10'(10'h100 + n1), 16'h0, 0);
            #1;
            if (cyc < 8) begin
                checkOutput("cont_ready0", req0_ready, (cyc % 2) == 0);
                checkOutput("cont_ready1", req1_ready, (cyc % 2) == 1);
                checkOutput("cont_ram_a", ram_a, (cyc % 2) ? 32'h100 + n1 : 32'(n0));
            end
            if (cyc > 0) begin
                c = cyc - 1;
                g = c % 2;
                checkOutput("cont_rsp0_valid", rsp0_valid, g == 0);
                checkOutput("cont_rsp1_valid", rsp1_valid, g == 1);
                if (g == 1) checkOutput("cont_rsp1_rdata", rsp1_rdata, 32'h100 + c / 2);
                else        checkOutput("cont_rsp0_rdata", rsp0_rdata, 32'(c / 2));
            end
            nextCycle();
        end

        // Single write by req0, then read-back by req1.
        applyStimulus(1, 1, 10'h005, 16'hBEEF, 0, 0, 0, 10'h000, 16'h0, 0);
        #1;
        checkOutput("wr_ready0", req0_ready, 1);
        checkOutput("wr_ram_we", ram_we, 1);
        checkOutput("wr_ram_a", ram_a, 32'h005);
        checkOutput("wr_ram_d", ram_d, 32'hBEEF);
        nextCycle();
        applyStimulus(0, 0, 10'h000, 16'h0, 0, 1, 0, 10'h005, 16'h0, 0);
        #1;
        checkOutput("rd_ready1", req1_ready, 1);
        checkOutput("rd_ram_we", ram_we, 0);
        checkOutput("rd_no_wr_rsp0", rsp0_valid, 0);
        checkOutput("rd_no_wr_rsp1", rsp1_valid, 0);
        nextCycle();
        applyStimulus(0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 0);
        #1;
        checkOutput("rd_rsp1_valid", rsp1_valid, 1);
        checkOutput("rd_rsp1_rdata", rsp1_rdata, 32'hBEEF);
        checkOutput("rd_rsp0_valid", rsp0_valid, 0);
        checkOutput("rd_rsp0_rdata", rsp0_rdata, 0);
        checkOutput("idle_ram_a_hold", ram_a, 32'h005);
        checkOutput("idle_ram_d_zero", ram_d, 0);
        checkOutput("idle_ram_we", ram_we, 0);
        nextCycle();
        checkOutput("idle_rsp1_once", rsp1_valid, 0);

        // req0 always valid, req1 valid every third cycle.
        for (int cyc = 0; cyc < 9; cyc++) begin
            applyStimulus(1, 0, 10'h010, 16'h0, 0, (cyc % 3) == 1, 0, 10'h020, 16'h0, 0);
            #1;
            checkOutput("gap_ready0", req0_ready, (cyc % 3) != 1);
            checkOutput("gap_ready1", req1_ready, (cyc % 3) == 1);
            if (cyc > 0) begin
                g = ((cyc - 1) % 3) == 1;
                checkOutput("gap_rsp1_valid", rsp1_valid, g);
                checkOutput("gap_rsp0_valid", rsp0_valid, !g);
                if (g) checkOutput("gap_rsp1_rdata", rsp1_rdata, 32'h020);
                else   checkOutput("gap_rsp0_rdata", rsp0_rdata, 32'h010);
            end
            nextCycle();
        end

        // req1 read accepted, then reset lands in the following cycle.
        applyStimulus(0, 0, 10'h000, 16'h0, 0, 1, 0, 10'h030, 16'h0, 0);
        #1;
        checkOutput("mid_ready1", req1_ready, 1);
        checkOutput("mid_prev_rsp0", rsp0_valid, 1);
        checkOutput("mid_prev_rdata0", rsp0_rdata, 32'h010);
        nextCycle();
        reset_n = 1'b0;
        applyStimulus(0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 0);
        nextCycle();
        checkOutput("mid_rst_rsp1", rsp1_valid, 0);
        checkOutput("mid_rst_rsp0", rsp0_valid, 0);
        reset_n = 1'b1;
        nextCycle();
        checkOutput("mid_post_rsp1", rsp1_valid, 0);
        checkOutput("mid_post_rdata1", rsp1_rdata, 0);

        // req0 locked 4-word write burst while req1 reads continuously.
        n0 = 0;
        prev_g = -1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            exp_g = lock_build ? (cyc < 4 ? 0 : 1) : (cyc % 2);
            applyStimulus(1, 1, 10'(10'h040 + n0), 16'(16'hA000 + n0), n0 < 3, 1, 0, 10'h050, 16'h0, 0);
            #1;
            checkOutput("lock_ready0", req0_ready, exp_g == 0);
            checkOutput("lock_ready1", req1_ready, exp_g == 1);
            checkOutput("lock_ram_we", ram_we, exp_g == 0);
            if (exp_g == 0) checkOutput("lock_ram_d", ram_d, 32'hA000 + n0);
            if (prev_g >= 0) checkOutput("lock_rsp1_valid", rsp1_valid, prev_g == 1);
            if (exp_g == 0) n0++;
            prev_g = exp_g;
            nextCycle();
        end
        applyStimulus(0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 0);
        #1;
        checkOutput("lock_last_rsp1", rsp1_valid, prev_g == 1);
        if (prev_g == 1) checkOutput("lock_last_rdata1", rsp1_rdata, 32'h050);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter that shares one single-port inferred RAM. The RAM has 1-cycle registered read latency and read-old-data on a same-cycle write.
- Requester 0 is the weight/image loader; it is write-heavy. Requester 1 is the layer inference sequencer; it is read-heavy.
- Per-cycle round-robin grant, valid/ready request handshake, and read-response return tagged to the winning requester.
- Sits between the loader/inference FSMs and the RAM instance; it owns the RAM a/d/we pins exclusively.

Parameters:
ADDR_WIDTH, 10, RAM address width
DATA_WIDTH, 16, RAM data width

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 access request
req0_ready  out  1  requester 0 access accepted this cycle
req0_we  in  1  1=write, 0=read
req0_addr  in  ADDR_WIDTH  access address
req0_wdata  in  DATA_WIDTH  write data
req0_lock  in  1  hold grant (used only with ARB_LOCK_EN)
rsp0_valid  out  1  read data for requester 0 valid
rsp0_rdata  out  DATA_WIDTH  read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, req1_lock, rsp1_valid, rsp1_rdata  as requester 0, for requester 1
ram_a  out  ADDR_WIDTH  RAM address
ram_d  out  DATA_WIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_q  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset (reset_n=0 at posedge):
  - last_grant<=1, so requester 0 wins the first contention.
  - rsp_tag<=0, rsp0_valid<=0, rsp1_valid<=0, lock_owner<=none.
  - While reset_n=0, req0_ready, req1_ready and ram_we are forced 0.
- Grant (combinational from registered state):
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - Neither valid: no grant.
- readyN=1 only for the winner. An access is accepted when validN & readyN, in the same cycle.
- RAM drive:
  - ram_a/ram_d come from the winner. With no winner, hold the previous ram_a and set ram_d=0.
  - ram_we = winner_we & accept.
- On each accept: last_grant<=winner.
- Read response:
  - A read accepted in cycle T gives rspN_valid=1 in cycle T+1 for exactly one cycle, and rspN_rdata=ram_q in that cycle.
  - The non-target requester sees rsp_valid=0. Its rdata is don't-care and is driven to 0.
  - Back-to-back reads by alternating requesters give responses every cycle with the correct tag; no bubbles.
- Writes produce no response.
- Read of an address written in the same cycle is impossible (single port). A read in T+1 of a T-write returns the new data.
- Throughput: one access per cycle total. Under full contention each requester gets 50%, strictly alternating.
- Requesters must hold valid/we/addr/wdata stable until ready. Behaviour is undefined otherwise.
- Reset mid-operation: a pending response from a read accepted in the cycle before reset is dropped; rsp valid is 0 after reset.
- FSM (lock_owner, ARB_LOCK_EN only): NONE -> OWN0/OWN1 on an accept with reqN_lock=1. OWNN -> NONE on an accept with reqN_lock=0, or on a cycle where reqN_valid=0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - While lock_owner=OWNN, requester N wins every cycle it is valid, regardless of last_grant. The other requester is stalled (ready=0) even when N is idle for that cycle; the release rule above still applies.
  - Intended for the loader's atomic multi-word bursts.
- Undefined:
  - reqN_lock ports exist but are ignored.
  - No lock_owner register; pure round-robin.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with both valid -> ready0=ready1=0, ram_we=0, rsp valids 0. Release with both valid -> requester 0 is granted first.
- Single writer: req0 writes addr 0x005, data 0xBEEF; then req1 reads 0x005 -> ram_we pulses one cycle. rsp1_valid=1 one cycle after req1 accept with rdata=0xBEEF; rsp0_valid stays 0.
- Contention: both continuously read, req0 addrs 0x000-0x003, req1 addrs 0x100-0x103, RAM preloaded with data=addr -> grants alternate 0,1,0,1...; each rspN_rdata equals its own addr, in order, one per accept.
- Idle gap: req1 valid only every 3rd cycle while req0 is always valid -> req1 is accepted in each cycle it is valid; req0 is accepted in all other cycles.
- Reset mid-read: assert reset_n=0 in the cycle after a req1 read accept -> rsp1_valid=0 after reset, no stale response.
- ARB_LOCK_EN: req0 writes 4 words with lock=1 on the first 3 and lock=0 on the last, while req1 is continuously valid -> req1_ready=0 for all 4 accepts; req1 is granted on the next cycle. Without the macro the same stimulus gives alternating grants.
